uart_rx_unit: RTL and testbench

- UART receive subsystem made of three parts: a mod-M baud-tick generator, a 16x-oversampling serial receiver, and a small FIFO that buffers received bytes.
- Takes the serial `rx` line in and gives the host a byte-wide read interface with empty/full status.
- Sits between the external RX pin and the host bus logic.

---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_rx_unit_if.sv | 12 +
 rtl/uart_baud_gen.sv | 39 +++
 rtl/uart_byte_fifo.sv | 87 ++++++++
 rtl/uart_rx_unit.sv | 171 +++++++++++++++++
 tb/tb_uart_rx_unit.sv | 191 +++++++++++++++++++
 6 files changed

// File: rtl/uart_pkg.sv
// Shared types and default parameters for the UART receive subsystem.
// Build option: UART_RX_FRAME_ERR_EN (adds frame_err to uart_rx_unit).
package uart_pkg;

    localparam int DBIT_DEF     = 8;
    localparam int SB_TICK_DEF  = 16;
    localparam int DVSR_DEF     = 163;
    localparam int DVSR_BIT_DEF = 8;
    localparam int FIFO_W_DEF   = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_e;

endpackage

// File: rtl/uart_rx_unit_if.sv
// Host-side byte read bus of the UART receiver (pop request, FWFT data, status).
interface uart_rx_unit_if #(
    parameter int DBIT = uart_pkg::DBIT_DEF
);
    logic            rd_uart;
    logic [DBIT-1:0] r_data;
    logic            rx_empty;
    logic            rx_full;

    modport master (output rd_uart, input r_data, input rx_empty, input rx_full);
    modport slave  (input rd_uart, output r_data, output rx_empty, output rx_full);
endinterface

// File: rtl/uart_baud_gen.sv
// Mod-DVSR counter producing a one-clock oversampling tick every DVSR clocks.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int DVSR     = DVSR_DEF,
    parameter int DVSR_BIT = DVSR_BIT_DEF
) (
    input  logic clk,
    input  logic reset,
    output logic s_tick
);

    logic [DVSR_BIT-1:0] q_q;
    logic [DVSR_BIT-1:0] q_d;
    logic                wrap_s;

    assign wrap_s = (q_q == DVSR_BIT'(DVSR - 1));
    assign s_tick = wrap_s;

    // next divisor count
    always_comb begin
        q_d = q_q;
        if (wrap_s) begin
            q_d = '0;
        end else begin
            q_d = q_q + DVSR_BIT'(1);
        end
    end

    // divisor counter register
    always_ff @(posedge clk) begin
        if (reset) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

endmodule

// File: rtl/uart_byte_fifo.sv
// Small first-word-fall-through FIFO buffering received bytes.
module uart_byte_fifo
    import uart_pkg::*;
#(
    parameter int DBIT   = DBIT_DEF,
    parameter int FIFO_W = FIFO_W_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            wr_req,
    input  logic [DBIT-1:0] w_data,
    input  logic            rd_req,
    output logic [DBIT-1:0] r_data,
    output logic            empty,
    output logic            full
);

    localparam int DEPTH = 2 ** FIFO_W;

    logic [DBIT-1:0]   mem_q [DEPTH];
    logic [DBIT-1:0]   mem_d [DEPTH];
    logic [FIFO_W-1:0] w_ptr_q, w_ptr_d;
    logic [FIFO_W-1:0] r_ptr_q, r_ptr_d;
    logic              empty_q, empty_d;
    logic              full_q, full_d;
    logic              wr_en_s;
    logic              rd_en_s;

    // gating uses the pre-update flags, so a write into a full FIFO is dropped even with a pop
    assign wr_en_s = wr_req & ~full_q;
    assign rd_en_s = rd_req & ~empty_q;
    assign r_data  = mem_q[r_ptr_q];
    assign empty   = empty_q;
    assign full    = full_q;

    // next pointers, flags and storage
    always_comb begin
        mem_d   = mem_q;
        w_ptr_d = w_ptr_q;
        r_ptr_d = r_ptr_q;
        empty_d = empty_q;
        full_d  = full_q;
        case ({wr_en_s, rd_en_s})
            2'b10: begin
                mem_d[w_ptr_q] = w_data;
                w_ptr_d        = w_ptr_q + FIFO_W'(1);
                empty_d        = 1'b0;
                full_d         = (w_ptr_d == r_ptr_q);
            end
            2'b01: begin
                r_ptr_d = r_ptr_q + FIFO_W'(1);
                full_d  = 1'b0;
                empty_d = (r_ptr_d == w_ptr_q);
            end
            2'b11: begin
                mem_d[w_ptr_q] = w_data;
                w_ptr_d        = w_ptr_q + FIFO_W'(1);
                r_ptr_d        = r_ptr_q + FIFO_W'(1);
            end
            default: begin
                w_ptr_d = w_ptr_q;
            end
        endcase
    end

    // FIFO state registers
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            w_ptr_q <= '0;
            r_ptr_q <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            w_ptr_q <= w_ptr_d;
            r_ptr_q <= r_ptr_d;
            empty_q <= empty_d;
            full_q  <= full_d;
        end
    end

endmodule

// File: rtl/uart_rx_unit.sv
// UART receive subsystem: baud generator, 16x-oversampling receiver FSM and byte FIFO.
// Build option: UART_RX_FRAME_ERR_EN adds frame_err and drops frames with a low stop bit.
module uart_rx_unit
    import uart_pkg::*;
#(
    parameter int DBIT     = DBIT_DEF,
    parameter int SB_TICK  = SB_TICK_DEF,
    parameter int DVSR     = DVSR_DEF,
    parameter int DVSR_BIT = DVSR_BIT_DEF,
    parameter int FIFO_W   = FIFO_W_DEF
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           rx,
    uart_rx_unit_if.slave  host,
    output logic           rx_done_tick,
    output logic           s_tick,
`ifdef UART_RX_FRAME_ERR_EN
    output logic           frame_err,
`endif
    output logic           overrun
);

    localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;
    // s widens only when a 1.5/2 stop-bit setting needs more than 16 ticks
    localparam int SW = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;

    rx_state_e       state_q, state_d;
    logic [SW-1:0]   s_q, s_d;
    logic [NW-1:0]   n_q, n_d;
    logic [DBIT-1:0] b_q, b_d;
    logic            done_q, done_d;
    logic            overrun_q, overrun_d;
    logic            wr_req_s;
`ifdef UART_RX_FRAME_ERR_EN
    logic            stop_bad_q, stop_bad_d;
    logic            ferr_q, ferr_d;
`endif

    uart_baud_gen #(.DVSR(DVSR), .DVSR_BIT(DVSR_BIT)) u_baud (
        .clk    (clk),
        .reset  (reset),
        .s_tick (s_tick)
    );

`ifdef UART_RX_FRAME_ERR_EN
    assign wr_req_s  = done_q & ~ferr_q;
    assign frame_err = ferr_q;
`else
    assign wr_req_s  = done_q;
`endif

    uart_byte_fifo #(.DBIT(DBIT), .FIFO_W(FIFO_W)) u_fifo (
        .clk    (clk),
        .reset  (reset),
        .wr_req (wr_req_s),
        .w_data (b_q),
        .rd_req (host.rd_uart),
        .r_data (host.r_data),
        .empty  (host.rx_empty),
        .full   (host.rx_full)
    );

    assign rx_done_tick = done_q;
    assign overrun      = overrun_q;

    // receiver next-state logic
    always_comb begin
        state_d   = state_q;
        s_d       = s_q;
        n_d       = n_q;
        b_d       = b_q;
        done_d    = 1'b0;
        overrun_d = overrun_q | (wr_req_s & host.rx_full);
`ifdef UART_RX_FRAME_ERR_EN
        stop_bad_d = stop_bad_q;
        ferr_d     = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (rx == 1'b0) begin
                    state_d = START;
                    s_d     = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            START: begin
                if (s_tick && (s_q == SW'(7))) begin
                    if (rx == 1'b0) begin
                        state_d = DATA;
                        s_d     = '0;
                        n_d     = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (s_tick) begin
                    s_d = s_q + SW'(1);
                end else begin
                    s_d = s_q;
                end
            end
            DATA: begin
                if (s_tick && (s_q == SW'(15))) begin
                    s_d = '0;
                    b_d = DBIT'({rx, b_q} >> 1);
                    if (n_q == NW'(DBIT - 1)) begin
                        state_d = STOP;
                    end else begin
                        n_d = n_q + NW'(1);
                    end
                end else if (s_tick) begin
                    s_d = s_q + SW'(1);
                end else begin
                    s_d = s_q;
                end
            end
            STOP: begin
                if (s_tick && (s_q == SW'(SB_TICK - 1))) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
`ifdef UART_RX_FRAME_ERR_EN
                    ferr_d  = stop_bad_q;
`endif
                end else if (s_tick) begin
                    s_d = s_q + SW'(1);
`ifdef UART_RX_FRAME_ERR_EN
                    if (s_q == SW'(7)) begin
                        stop_bad_d = ~rx;
                    end else begin
                        stop_bad_d = stop_bad_q;
                    end
`endif
                end else begin
                    s_d = s_q;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // receiver registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            s_q        <= '0;
            n_q        <= '0;
            b_q        <= '0;
            done_q     <= 1'b0;
            overrun_q  <= 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
            stop_bad_q <= 1'b0;
            ferr_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            s_q        <= s_d;
            n_q        <= n_d;
            b_q        <= b_d;
            done_q     <= done_d;
            overrun_q  <= overrun_d;
`ifdef UART_RX_FRAME_ERR_EN
            stop_bad_q <= stop_bad_d;
            ferr_q     <= ferr_d;
`endif
        end
    end

endmodule

// File: tb/tb_uart_rx_unit.sv
// Directed testbench for uart_rx_unit; a short divisor keeps the frame sequence brief.
module tb_uart_rx_unit;
    import uart_pkg::*;

    localparam int DVSR_TB  = 16;
    localparam int BIT_CLKS = 16 * DVSR_TB;

    logic clk;
    logic reset;
    logic rx;
    logic rx_done_tick;
    logic s_tick;
    logic overrun;
`ifdef UART_RX_FRAME_ERR_EN
    logic frame_err;
    int   ferr_cnt;
`endif

    int tests;
    int fails;
    int done_cnt;
    int base;
    int k;
    int waited;

    uart_rx_unit_if #(.DBIT(8)) bus ();

    uart_rx_unit #(
        .DBIT(8), .SB_TICK(16), .DVSR(DVSR_TB), .DVSR_BIT(8), .FIFO_W(2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .rx           (rx),
        .host         (bus.slave),
        .rx_done_tick (rx_done_tick),
        .s_tick       (s_tick),
`ifdef UART_RX_FRAME_ERR_EN
        .frame_err    (frame_err),
`endif
        .overrun      (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rx_done_tick) done_cnt <= done_cnt + 1;
`ifdef UART_RX_FRAME_ERR_EN
        if (frame_err) ferr_cnt <= ferr_cnt + 1;
`endif
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] data, input logic stop_bit);
        rx = 1'b0;
        wait_clks(BIT_CLKS);
        for (int i = 0; i < 8; i++) begin
            rx = data[i];
            wait_clks(BIT_CLKS);
        end
        rx = stop_bit;
        wait_clks(BIT_CLKS);
        rx = 1'b1;
    endtask

    task automatic pop();
        bus.rd_uart = 1'b1;
        @(negedge clk);
        bus.rd_uart = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_state"},   32'(dut.state_q), 32'(IDLE));
        check({tag, "_empty"},   32'(bus.rx_empty), 32'd1);
        check({tag, "_full"},    32'(bus.rx_full), 32'd0);
        check({tag, "_done"},    32'(rx_done_tick), 32'd0);
        check({tag, "_overrun"}, 32'(overrun), 32'd0);
        check({tag, "_stick"},   32'(s_tick), 32'd0);
        check({tag, "_rdata"},   32'(bus.r_data), 32'd0);
    endtask

    initial begin
        tests       = 0;
        fails       = 0;
        done_cnt    = 0;
`ifdef UART_RX_FRAME_ERR_EN
        ferr_cnt    = 0;
`endif
        reset       = 1'b1;
        rx          = 1'b1;
        bus.rd_uart = 1'b0;
        wait_clks(2);
        check_reset_state("rst");
        reset = 1'b0;

        // idle line: nothing received, tick period is DVSR_TB
        wait_clks(5000);
        check("idle_empty", 32'(bus.rx_empty), 32'd1);
        check("idle_done_cnt", 32'(done_cnt), 32'd0);
        waited = 0;
        while (s_tick !== 1'b1 && waited < 2 * DVSR_TB) begin
            @(negedge clk);
            waited++;
        end
        check("stick_found", 32'(s_tick), 32'd1);
        @(negedge clk);
        check("stick_one_clk", 32'(s_tick), 32'd0);
        k = 1;
        while (s_tick !== 1'b1 && k < 2 * DVSR_TB) begin
            @(negedge clk);
            k++;
        end
        check("stick_period", 32'(k), 32'(DVSR_TB));

        // single frame 0xB2
        send_frame(8'hB2, 1'b1);
        check("b2_done_cnt", 32'(done_cnt), 32'd1);
        check("b2_rdata", 32'(bus.r_data), 32'h0000_00B2);
        check("b2_empty", 32'(bus.rx_empty), 32'd0);
        pop();
        check("b2_pop_empty", 32'(bus.rx_empty), 32'd1);

        // fill the FIFO, then overflow it
        for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b1);
        check("fill_full", 32'(bus.rx_full), 32'd1);
        check("fill_no_overrun", 32'(overrun), 32'd0);
        send_frame(8'h55, 1'b1);
        check("ovf_overrun", 32'(overrun), 32'd1);
        check("ovf_done_cnt", 32'(done_cnt), 32'd6);
        for (int i = 1; i <= 4; i++) begin
            check($sformatf("drain_%0d", i), 32'(bus.r_data), 32'(i));
            pop();
        end
        check("drain_empty", 32'(bus.rx_empty), 32'd1);
        check("drain_full", 32'(bus.rx_full), 32'd0);
        check("drain_overrun_sticky", 32'(overrun), 32'd1);

        // glitch of four ticks is rejected as a false start
        base = done_cnt;
        rx = 1'b0;
        wait_clks(4 * DVSR_TB);
        rx = 1'b1;
        wait_clks(BIT_CLKS * 11);
        check("glitch_state", 32'(dut.state_q), 32'(IDLE));
        check("glitch_empty", 32'(bus.rx_empty), 32'd1);
        check("glitch_done_cnt", 32'(done_cnt), 32'(base));

        // reset in the middle of the data bits
        rx = 1'b0;
        wait_clks(BIT_CLKS * 4);
        check("mid_in_data", 32'(dut.state_q), 32'(DATA));
        reset = 1'b1;
        wait_clks(2);
        check_reset_state("midrst");
        reset = 1'b0;
        rx    = 1'b1;
        wait_clks(BIT_CLKS * 2);
        check("post_rst_empty", 32'(bus.rx_empty), 32'd1);
        base = done_cnt;
        send_frame(8'h3C, 1'b1);
        check("3c_done_cnt", 32'(done_cnt), 32'(base + 1));
        check("3c_rdata", 32'(bus.r_data), 32'h0000_003C);
        pop();
        check("3c_pop_empty", 32'(bus.rx_empty), 32'd1);

`ifdef UART_RX_FRAME_ERR_EN
        // stop bit held low: byte discarded with frame_err
        wait_clks(BIT_CLKS);
        base = done_cnt;
        send_frame(8'hA5, 1'b0);
        check("fe_pulse_cnt", 32'(ferr_cnt), 32'd1);
        check("fe_done_cnt", 32'(done_cnt), 32'(base + 1));
        check("fe_empty", 32'(bus.rx_empty), 32'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
